// File: rtl/segasys1_romdl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : segasys1_romdl                                                |
// | Purpose  : ROM download sequencer. Buffers the ioctl byte stream in a    |
// |            small FIFO and replays it onto the shared ROMAD/ROMDT/ROMEN   |
// |            bus at a paced rate, holding the CPUs in reset until the      |
// |            whole image has been written.                                 |
// | Ports    : clk, reset (async, active-high)                               |
// |            ioctl_download/index/wr/addr/dout  - HPS byte stream in       |
// |            ioctl_wait                         - FIFO-full backpressure   |
// |            ROMAD/ROMDT/ROMEN                  - download bus to DLROMs   |
// |            cpu_hold, rom_ready                - boot control             |
// |            byte_count, checksum, overflow     - download status          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module segasys1_romdl #(
  parameter logic [7:0]  ROM_INDEX = 8'h00,
  parameter logic [24:0] ROM_SIZE  = 25'h2C200,
  parameter int          FIFO_AW   = 2,
  parameter int          STRIDE    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [24:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        cpu_hold,
  output logic        rom_ready,
  output logic [17:0] byte_count,
  output logic [7:0]  checksum,
  output logic        overflow
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int PACE_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [PACE_W-1:0]  PACE_RELOAD = PACE_W'((STRIDE > 1) ? (STRIDE - 1) : 0);
  localparam logic [PACE_W-1:0]  PACE_ONE    = PACE_W'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE     = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE     = FIFO_AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               dl_prev_q, dl_prev_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [PACE_W-1:0]  pace_q, pace_d;
  logic               wait_q, wait_d;
  logic [24:0]        romad_q, romad_d;
  logic [7:0]         romdt_q, romdt_d;
  logic               romen_q, romen_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               rom_ready_q, rom_ready_d;
  logic [17:0]        byte_count_q, byte_count_d;
  logic [7:0]         checksum_q, checksum_d;
  logic               overflow_q, overflow_d;

  // Entry layout: {addr[24:0], data[7:0]}
  logic [32:0] fifo_mem [DEPTH];
  logic [32:0] fifo_head;

  logic idx_match, dl_rise, dl_fall, enter_load;
  logic qualify, fifo_full, push, pop;

  always_comb begin
    fifo_head  = fifo_mem[rd_ptr_q];
    idx_match  = (ioctl_index == ROM_INDEX);
    dl_rise    = ioctl_download & ~dl_prev_q;
    dl_fall    = ~ioctl_download & dl_prev_q;
    // A matching rising edge restarts the download from any state but LOAD
    // (LOAD cannot see a new rising edge without first seeing a falling one).
    enter_load = dl_rise & idx_match & (state_q != ST_LOAD);
    fifo_full  = (count_q == CNT_FULL);
    qualify    = (state_q == ST_LOAD) & ioctl_wr & ioctl_download & idx_match &
                 (ioctl_addr < ROM_SIZE);
    push       = qualify & ~fifo_full;
    pop        = (count_q != '0) & (pace_q == '0) & ~enter_load;
  end

  always_comb begin
    state_d      = state_q;
    dl_prev_d    = ioctl_download;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pace_d       = pace_q;
    romad_d      = romad_q;
    romdt_d      = romdt_q;
    romen_d      = pop;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    overflow_d   = overflow_q;

    case (state_q)
      ST_IDLE:  if (enter_load) state_d = ST_LOAD;
      ST_LOAD:  if (dl_fall) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enter_load) begin
          state_d = ST_LOAD;
        // Wait for the last strobe to complete before declaring the image done.
        end else if ((count_q == '0) && !romen_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  if (enter_load) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase

    if (enter_load) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pace_d       = '0;
      byte_count_d = '0;
      checksum_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d     = wr_ptr_q + PTR_ONE;
        byte_count_d = byte_count_q + 18'd1;
        checksum_d   = checksum_q + ioctl_dout;
      end
      if (qualify && fifo_full) overflow_d = 1'b1;

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        romad_d  = fifo_head[32:8];
        romdt_d  = fifo_head[7:0];
        pace_d   = PACE_RELOAD;
      end else if (pace_q != '0) begin
        pace_d = pace_q - PACE_ONE;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    wait_d      = (count_d == CNT_FULL);
    rom_ready_d = (state_d == ST_DONE);
    // Release the CPUs only on the second clock spent in DONE.
    cpu_hold_d  = !((state_q == ST_DONE) && (state_d == ST_DONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dl_prev_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pace_q       <= '0;
      wait_q       <= 1'b0;
      romad_q      <= '0;
      romdt_q      <= '0;
      romen_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      rom_ready_q  <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= dl_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pace_q       <= pace_d;
      wait_q       <= wait_d;
      romad_q      <= romad_d;
      romdt_q      <= romdt_d;
      romen_q      <= romen_d;
      cpu_hold_q   <= cpu_hold_d;
      rom_ready_q  <= rom_ready_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
  end

  assign ioctl_wait = wait_q;
  assign ROMAD      = romad_q;
  assign ROMDT      = romdt_q;
  assign ROMEN      = romen_q;
  assign cpu_hold   = cpu_hold_q;
  assign rom_ready  = rom_ready_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_segasys1_romdl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_segasys1_romdl                                             |
// | Purpose  : Directed self-checking bench for segasys1_romdl. Two copies   |
// |            share the stimulus: one paced at STRIDE=2, one at STRIDE=4.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_segasys1_romdl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        ioctl_wait_2, ROMEN_2, cpu_hold_2, rom_ready_2, overflow_2;
  logic [24:0] ROMAD_2;
  logic [7:0]  ROMDT_2, checksum_2;
  logic [17:0] byte_count_2;

  logic        ioctl_wait_4, ROMEN_4, cpu_hold_4, rom_ready_4, overflow_4;
  logic [24:0] ROMAD_4;
  logic [7:0]  ROMDT_4, checksum_4;
  logic [17:0] byte_count_4;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RESET_VEC = {1'b0, 25'd0, 8'd0, 1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 1'b0};

  logic [63:0] out_2, out_4;
  assign out_2 = {ioctl_wait_2, ROMAD_2, ROMDT_2, ROMEN_2, cpu_hold_2, rom_ready_2,
                  byte_count_2, checksum_2, overflow_2};
  assign out_4 = {ioctl_wait_4, ROMAD_4, ROMDT_4, ROMEN_4, cpu_hold_4, rom_ready_4,
                  byte_count_4, checksum_4, overflow_4};

  always #5 clk = ~clk;

  segasys1_romdl #(.ROM_INDEX(8'h00), .ROM_SIZE(25'h2C200), .FIFO_AW(2), .STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait_2), .ROMAD(ROMAD_2), .ROMDT(ROMDT_2), .ROMEN(ROMEN_2),
    .cpu_hold(cpu_hold_2), .rom_ready(rom_ready_2), .byte_count(byte_count_2),
    .checksum(checksum_2), .overflow(overflow_2));

  segasys1_romdl #(.ROM_INDEX(8'h00), .ROM_SIZE(25'h2C200), .FIFO_AW(2), .STRIDE(4)) dut4 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait_4), .ROMAD(ROMAD_4), .ROMDT(ROMDT_4), .ROMEN(ROMEN_4),
    .cpu_hold(cpu_hold_4), .rom_ready(rom_ready_4), .byte_count(byte_count_4),
    .checksum(checksum_4), .overflow(overflow_4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(rom_ready_2 && rom_ready_4) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!(rom_ready_2 && rom_ready_4)) begin
      errors++;
      $display("FAIL wait_done: rom_ready_2=%0b rom_ready_4=%0b, required 1 1", rom_ready_2, rom_ready_4);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    #12;
    checks++;
    if (out_2 !== RESET_VEC || out_4 !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h / %h, required %h", out_2, out_4, RESET_VEC);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    checks++;
    if (out_2 !== RESET_VEC) begin
      errors++;
      $display("FAIL idle_after_reset: got %h, required %h", out_2, RESET_VEC);
    end
  endtask

  task automatic test_basic_download();
    logic [7:0] data [4];
    int  pulse_n = 0;
    bit  seen_wait = 1'b0;
    logic [24:0] exp_ad;
    logic [7:0]  exp_dt;
    data = '{8'hA5, 8'h5A, 8'hFF, 8'h01};
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 40 && !rom_ready_2; i++) begin
      if (i < 4) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = data[i];
      end else begin
        ioctl_wr = 1'b0;
      end
      if (i == 4) ioctl_download = 1'b0;
      tick();
      if (ioctl_wait_2) seen_wait = 1'b1;
      if (ROMEN_2) begin
        exp_ad = 25'(pulse_n);
        exp_dt = (pulse_n < 4) ? data[pulse_n] : 8'h00;
        checks++;
        if (pulse_n >= 4 || ROMAD_2 !== exp_ad || ROMDT_2 !== exp_dt || i != 1 + 2 * pulse_n) begin
          errors++;
          $display("FAIL basic_pulse%0d: got ad=%h dt=%h cycle=%0d, required ad=%h dt=%h cycle=%0d",
                   pulse_n, ROMAD_2, ROMDT_2, i, exp_ad, exp_dt, 1 + 2 * pulse_n);
        end
        pulse_n++;
      end
    end
    checks++;
    if (pulse_n != 4) begin
      errors++;
      $display("FAIL basic_pulse_count: got %0d, required 4", pulse_n);
    end
    checks++;
    if (seen_wait !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait: got %0b, required 0 (occupancy never reaches 4)", seen_wait);
    end
    checks++;
    if ({rom_ready_2, cpu_hold_2} !== 2'b11) begin
      errors++;
      $display("FAIL done_entry: got rom_ready=%0b cpu_hold=%0b, required 1 1", rom_ready_2, cpu_hold_2);
    end
    checks++;
    if (byte_count_2 !== 18'd4 || checksum_2 !== 8'hFF) begin
      errors++;
      $display("FAIL basic_status: got count=%0d sum=%h, required 4 FF", byte_count_2, checksum_2);
    end
    tick();
    checks++;
    if ({rom_ready_2, cpu_hold_2} !== 2'b10) begin
      errors++;
      $display("FAIL cpu_release: got rom_ready=%0b cpu_hold=%0b, required 1 0", rom_ready_2, cpu_hold_2);
    end
  endtask

  task automatic test_restart();
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    checks++;
    if ({rom_ready_2, cpu_hold_2, rom_ready_4, cpu_hold_4} !== 4'b0101) begin
      errors++;
      $display("FAIL restart_ctrl: got %b, required 0101",
               {rom_ready_2, cpu_hold_2, rom_ready_4, cpu_hold_4});
    end
    checks++;
    if (byte_count_2 !== 18'd0 || checksum_2 !== 8'h00 || overflow_2 !== 1'b0) begin
      errors++;
      $display("FAIL restart_status: got count=%0d sum=%h ovf=%0b, required 0 00 0",
               byte_count_2, checksum_2, overflow_2);
    end
  endtask

  task automatic test_filter();
    int pulses = 0;
    ioctl_wr = 1'b1; ioctl_addr = 25'h2C200; ioctl_dout = 8'h77;
    tick();
    if (ROMEN_2 || ROMEN_4) pulses++;
    ioctl_index = 8'h01; ioctl_addr = 25'h5; ioctl_dout = 8'h88;
    tick();
    if (ROMEN_2 || ROMEN_4) pulses++;
    ioctl_wr = 1'b0; ioctl_index = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ROMEN_2 || ROMEN_4) pulses++;
    end
    checks++;
    if (pulses != 0 || byte_count_2 !== 18'd0 || byte_count_4 !== 18'd0) begin
      errors++;
      $display("FAIL filter: got pulses=%0d count=%0d/%0d, required 0 0/0",
               pulses, byte_count_2, byte_count_4);
    end
  endtask

  task automatic test_boundary();
    bit got = 1'b0;
    logic [24:0] ad = '0;
    logic [7:0]  dt = '0;
    ioctl_wr = 1'b1; ioctl_addr = 25'h2C1FF; ioctl_dout = 8'h3C;
    tick();
    ioctl_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ROMEN_2 && !got) begin
        got = 1'b1; ad = ROMAD_2; dt = ROMDT_2;
      end
    end
    checks++;
    if (!got || ad !== 25'h2C1FF || dt !== 8'h3C) begin
      errors++;
      $display("FAIL boundary_write: got seen=%0b ad=%h dt=%h, required 1 2C1FF 3C", got, ad, dt);
    end
    checks++;
    if (ROMEN_2 !== 1'b0 || ROMAD_2 !== 25'h2C1FF || ROMDT_2 !== 8'h3C) begin
      errors++;
      $display("FAIL bus_hold: got en=%0b ad=%h dt=%h, required 0 2C1FF 3C", ROMEN_2, ROMAD_2, ROMDT_2);
    end
    checks++;
    if (byte_count_2 !== 18'd1 || checksum_2 !== 8'h3C) begin
      errors++;
      $display("FAIL boundary_status: got count=%0d sum=%h, required 1 3C", byte_count_2, checksum_2);
    end
    ioctl_download = 1'b0;
    wait_done();
  endtask

  task automatic test_overflow();
    int pulses = 0;
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
      tick();
      if (ROMEN_4) pulses++;
      if (i == 3) begin
        checks++;
        if (ioctl_wait_4 !== 1'b0) begin
          errors++;
          $display("FAIL wait_at_3: got %0b, required 0", ioctl_wait_4);
        end
      end
      if (i == 4) begin
        checks++;
        if ({ioctl_wait_4, overflow_4} !== 2'b10) begin
          errors++;
          $display("FAIL wait_full: got wait=%0b ovf=%0b, required 1 0", ioctl_wait_4, overflow_4);
        end
      end
      if (i == 5) begin
        checks++;
        if ({ioctl_wait_4, overflow_4} !== 2'b01) begin
          errors++;
          $display("FAIL overflow_set: got wait=%0b ovf=%0b, required 0 1", ioctl_wait_4, overflow_4);
        end
      end
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    for (int i = 0; i < 80 && !rom_ready_4; i++) begin
      tick();
      if (ROMEN_4) pulses++;
    end
    checks++;
    if (pulses != 5 || byte_count_4 !== 18'd5 || overflow_4 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_result: got pulses=%0d count=%0d ovf=%0b, required 5 5 1",
               pulses, byte_count_4, overflow_4);
    end
    checks++;
    if (overflow_2 !== 1'b0 || byte_count_2 !== 18'd6) begin
      errors++;
      $display("FAIL no_overflow_stride2: got ovf=%0b count=%0d, required 0 6", overflow_2, byte_count_2);
    end
    wait_done();
  endtask

  task automatic test_foreign_index();
    ioctl_index = 8'h05; ioctl_download = 1'b1;
    tick();
    tick();
    checks++;
    if ({rom_ready_2, cpu_hold_2, rom_ready_4, cpu_hold_4} !== 4'b1010) begin
      errors++;
      $display("FAIL foreign_index: got %b, required 1010",
               {rom_ready_2, cpu_hold_2, rom_ready_4, cpu_hold_4});
    end
    ioctl_download = 1'b0;
    tick();
    ioctl_index = 8'h00;
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(16 + i); ioctl_dout = 8'(8'h40 + i);
      tick();
    end
    ioctl_wr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_4 !== RESET_VEC || out_2 !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h / %h, required %h", out_2, out_4, RESET_VEC);
    end
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ROMEN_2 || ROMEN_4) pulses++;
    end
    checks++;
    if (pulses != 0 || out_4 !== RESET_VEC || out_2 !== RESET_VEC) begin
      errors++;
      $display("FAIL post_reset_quiet: got pulses=%0d out=%h / %h, required 0 %h",
               pulses, out_2, out_4, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_basic_download();
    wait_done();
    test_restart();
    test_filter();
    test_boundary();
    test_overflow();
    test_foreign_index();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
